// File: rtl/matmul_rr_scheduler.sv
// Round-robin front end that lets two requesters share one matrix multiplier.
// It holds the accepted operands, pulses start, and returns C (or an abort) to the owner.
module matmul_rr_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int M              = 8,
  parameter int N              = 8,
  parameter int P              = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [M*N*DATA_WIDTH-1:0]  req0_a,
  input  logic [N*P*DATA_WIDTH-1:0]  req0_b,
  input  logic [M*N*DATA_WIDTH-1:0]  req1_a,
  input  logic [N*P*DATA_WIDTH-1:0]  req1_b,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [M*P*DATA_WIDTH-1:0]  rsp_c,
  output logic                       rsp_error,
  output logic                       mm_start,
  output logic [M*N*DATA_WIDTH-1:0]  mm_matrix_a,
  output logic [N*P*DATA_WIDTH-1:0]  mm_matrix_b,
  input  logic                       mm_done,
  input  logic [M*P*DATA_WIDTH-1:0]  mm_result_c,
  output logic                       busy,
  output logic [CNT_W-1:0]           job_count
);

  localparam int AW = M * N * DATA_WIDTH;
  localparam int BW = N * P * DATA_WIDTH;
  localparam int CW = M * P * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_DONE, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             owner_reg;
  logic [CNT_W-1:0] wdog_reg;
  logic [CNT_W-1:0] job_count_reg;
  logic [1:0]       rsp_valid_reg;
  logic [CW-1:0]    rsp_c_reg;
  logic             rsp_error_reg;
  logic [AW-1:0]    a_reg;
  logic [BW-1:0]    b_reg;

  logic grant_valid;
  logic grant;
  logic timeout;
  logic done_hit;

  // On a tie the requester that did not win last time gets the slot.
  assign grant_valid = |req_valid;
  assign grant       = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
  assign timeout     = (wdog_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done_hit    = (state_reg == WAIT_DONE) && mm_done;

  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req_ready[grant] = 1'b1;
          state_next       = START;
        end
      end
      START: state_next = WAIT_LOW;
      WAIT_LOW: begin
        if (timeout)       state_next = RESP;
        else if (!mm_done) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mm_done || timeout) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      wdog_reg       <= '0;
      job_count_reg  <= '0;
      rsp_valid_reg  <= 2'b00;
      rsp_c_reg      <= '0;
      rsp_error_reg  <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            a_reg          <= grant ? req1_a : req0_a;
            b_reg          <= grant ? req1_b : req0_b;
            owner_reg      <= grant;
            last_grant_reg <= grant;
            wdog_reg       <= '0;
          end
        end
        WAIT_LOW, WAIT_DONE: begin
          // A done seen in the same cycle as the timeout still counts as success.
          if (done_hit) begin
            rsp_c_reg     <= mm_result_c;
            rsp_error_reg <= 1'b0;
            rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          end else if (timeout) begin
            rsp_c_reg     <= '0;
            rsp_error_reg <= 1'b1;
            rsp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner_reg]) begin
            rsp_valid_reg <= 2'b00;
            job_count_reg <= job_count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mm_start    = (state_reg == START);
  assign busy        = (state_reg != IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_c       = rsp_c_reg;
  assign rsp_error   = rsp_error_reg;
  assign mm_matrix_a = a_reg;
  assign mm_matrix_b = b_reg;
  assign job_count   = job_count_reg;

endmodule

// File: tb/tb_matmul_rr_scheduler.sv
// Directed bench for matmul_rr_scheduler on 2x2 matrices with a behavioural multiplier stub.
module tb_matmul_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp_c, mm_matrix_a, mm_matrix_b, mm_result_c;
  logic        rsp_error, mm_start, mm_done, busy;
  logic [15:0] job_count;

  logic        manual, man_done, stub_done;
  logic [31:0] man_c, stub_c;
  int          stub_cnt;
  int          start_count = 0;
  int          checks = 0;
  int          passes = 0;

  matmul_rr_scheduler #(
    .DATA_WIDTH(8), .M(2), .N(2), .P(2), .TIMEOUT_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_error(rsp_error),
    .mm_start(mm_start), .mm_matrix_a(mm_matrix_a), .mm_matrix_b(mm_matrix_b),
    .mm_done(mm_done), .mm_result_c(mm_result_c),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  // 2x2 product of 8-bit elements, truncated to 8 bits per element.
  function automatic logic [31:0] mm2(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] c;
    logic [7:0]  s;
    c = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = '0;
        for (int k = 0; k < 2; k++) s = s + a[(i*2+k)*8 +: 8] * b[(k*2+j)*8 +: 8];
        c[(i*2+j)*8 +: 8] = s;
      end
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_c    <= '0;
    end else if (mm_start) begin
      stub_done <= 1'b0;
      stub_cnt  <= 3;
    end else if (stub_cnt == 1) begin
      stub_done <= 1'b1;
      stub_c    <= mm2(mm_matrix_a, mm_matrix_b);
      stub_cnt  <= 0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) if (mm_start) start_count <= start_count + 1;

  assign mm_done     = manual ? man_done : stub_done;
  assign mm_result_c = manual ? man_c : stub_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_rsp();
    int cyc = 0;
    while (rsp_valid == 2'b00 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_wait_bound", 64'(cyc < 100), 64'd1);
  endtask

  task automatic finish_rsp(input logic [1:0] who);
    rsp_ready = who;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic tie_job(input logic [1:0] exp_owner, input logic [31:0] exp_c);
    #1 check("tie_grant", 64'(req_ready), 64'(exp_owner));
    @(negedge clk);
    check("tie_start", 64'(mm_start), 64'd1);
    wait_rsp();
    check("tie_owner", 64'(rsp_valid), 64'(exp_owner));
    check("tie_c", 64'(rsp_c), 64'(exp_c));
    $display("job owner=%b c=%h err=%b", rsp_valid, rsp_c, rsp_error);
    finish_rsp(exp_owner);
  endtask

  initial begin
    logic flag;
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic flag;
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    manual = 1'b0; man_done = 1'b0; man_c = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_c", 64'(rsp_c), 64'd0);
    check("rst_mm_start", 64'(mm_start), 64'd0);
    check("rst_mm_a", 64'(mm_matrix_a), 64'd0);
    check("rst_job_count", 64'(job_count), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single job from requester 0: identity A, so C must equal B.
    req0_a = 32'h01000001; req0_b = 32'h04030201; req_valid = 2'b01;
    #1 check("t1_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    check("t1_start", 64'(mm_start), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_busy", 64'(req_ready), 64'd0);
    check("t1_mm_b", 64'(mm_matrix_b), 64'h04030201);
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_start_pulse", 64'(mm_start), 64'd0);
    wait_rsp();
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_c", 64'(rsp_c), 64'h04030201);
    check("t1_rsp_error", 64'(rsp_error), 64'd0);
    check("t1_start_count", 64'(start_count), 64'd1);
    $display("job owner=%b c=%h err=%b", rsp_valid, rsp_c, rsp_error);
    finish_rsp(2'b01);
    check("t1_rsp_drop", 64'(rsp_valid), 64'd0);
    check("t1_job_count", 64'(job_count), 64'd1);

    // Fresh reset so the tie sequence starts with requester 0.
    rst = 1'b0;
    @(negedge clk);
    check("rst2_job_count", 64'(job_count), 64'd0);
    rst = 1'b1;

    // Four tied jobs, A=[1 2;3 4], distinct B each time.
    req0_a = 32'h04030201; req1_a = 32'h04030201;
    req0_b = 32'h01000001; req1_b = 32'h02000002;
    req_valid = 2'b11;
    tie_job(2'b01, 32'h04030201);
    req0_b = 32'h00010100;
    tie_job(2'b10, 32'h08060402);
    req1_b = 32'h64646464;
    tie_job(2'b01, 32'h03040102);
    tie_job(2'b10, 32'hBCBC2C2C);
    req_valid = 2'b00;
    check("t2_start_count", 64'(start_count), 64'd5);
    check("t2_job_count", 64'(job_count), 64'd4);

    // Stale done held high through START must not complete the job.
    manual = 1'b1; man_done = 1'b1; man_c = 32'hDEADBEEF;
    req0_a = 32'h01000001; req0_b = 32'h55667788; req_valid = 2'b01;
    #1 check("t3_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) flag = 1'b1;
    end
    check("t3_stale_ignored", 64'(flag), 64'd0);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_wait_low", 64'(rsp_valid), 64'd0);
    man_c = 32'h11223344; man_done = 1'b1;
    @(negedge clk);
    check("t3_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t3_rsp_c", 64'(rsp_c), 64'h11223344);
    check("t3_rsp_error", 64'(rsp_error), 64'd0);
    $display("job owner=%b c=%h err=%b", rsp_valid, rsp_c, rsp_error);
    finish_rsp(2'b01);
    check("t3_job_count", 64'(job_count), 64'd5);

    // Watchdog abort after 16 cycles in WAIT_LOW/WAIT_DONE, then backpressure.
    man_done = 1'b0;
    req1_a = 32'h01010101; req1_b = 32'h02020202; req_valid = 2'b10;
    #1 check("t4_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    check("t4_start", 64'(mm_start), 64'd1);
    req_valid = 2'b00;
    flag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) flag = 1'b1;
    end
    check("t4_no_early_rsp", 64'(flag), 64'd0);
    @(negedge clk);
    check("t4_rsp_valid", 64'(rsp_valid), 64'h2);
    check("t4_rsp_error", 64'(rsp_error), 64'd1);
    check("t4_rsp_c", 64'(rsp_c), 64'd0);
    $display("job owner=%b c=%h err=%b", rsp_valid, rsp_c, rsp_error);
    req_valid = 2'b01; rsp_ready = 2'b01;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b10 || rsp_error !== 1'b1 || rsp_c !== 32'h0 || req_ready !== 2'b00)
        flag = 1'b1;
    end
    check("t5_bp_stable", 64'(flag), 64'd0);
    finish_rsp(2'b10);
    check("t5_rsp_drop", 64'(rsp_valid), 64'd0);
    check("t5_job_count", 64'(job_count), 64'd6);
    check("t5_ready_after", 64'(req_ready), 64'h1);
    man_c = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    check("t5_new_valid", 64'(rsp_valid), 64'h1);
    check("t5_new_error", 64'(rsp_error), 64'd0);
    check("t5_new_c", 64'(rsp_c), 64'hCAFEF00D);
    $display("job owner=%b c=%h err=%b", rsp_valid, rsp_c, rsp_error);
    finish_rsp(2'b01);
    check("t5_job_count2", 64'(job_count), 64'd7);

    // Reset while waiting for done abandons the job.
    man_done = 1'b0;
    req1_a = 32'h01010101; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("t6_busy_pre", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rsp_c", 64'(rsp_c), 64'd0);
    check("t6_rsp_error", 64'(rsp_error), 64'd0);
    check("t6_mm_a", 64'(mm_matrix_a), 64'd0);
    check("t6_mm_b", 64'(mm_matrix_b), 64'd0);
    check("t6_job_count", 64'(job_count), 64'd0);
    check("t6_mm_start", 64'(mm_start), 64'd0);
    rst = 1'b1; man_done = 1'b1; man_c = 32'h99999999;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) flag = 1'b1;
    end
    check("t6_no_rsp", 64'(flag), 64'd0);
    req0_a = 32'h0A0B0C0D; req_valid = 2'b11;
    #1 check("t6_tie_req0", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;
    check("t6_latched_a", 64'(mm_matrix_a), 64'h0A0B0C0D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
